// File: rtl/interface_response_router_if.sv
// Bundle of request-tracking and response-routing signals between the shared port,
// the router and the per-master adapters.
interface interface_response_router_if #(
   parameter int IN_COUNT   = 2,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
);
   localparam int SW = $clog2(IN_COUNT) + 1;
   localparam int CW = $clog2(DEPTH) + 1;

   logic                  req_accept_i;
   logic [SW-1:0]         req_sel_i;
   logic                  req_stall_o;
   logic                  rsp_valid_i;
   logic [DATA_WIDTH-1:0] rsp_data_i;
   logic                  rsp_ready_o;
   logic [IN_COUNT-1:0]   rsp_valid_o;
   logic [DATA_WIDTH-1:0] rsp_data_o;
   logic [IN_COUNT-1:0]   rsp_ready_i;
   logic [CW-1:0]         outstanding_o;
   logic                  err_o;

   // Router side.
   modport slave (
      input  req_accept_i, req_sel_i, rsp_valid_i, rsp_data_i, rsp_ready_i,
      output req_stall_o, rsp_ready_o, rsp_valid_o, rsp_data_o, outstanding_o, err_o
   );

   // Environment side: arbiter, shared slave and master adapters.
   modport master (
      output req_accept_i, req_sel_i, rsp_valid_i, rsp_data_i, rsp_ready_i,
      input  req_stall_o, rsp_ready_o, rsp_valid_o, rsp_data_o, outstanding_o, err_o
   );
endinterface

// File: rtl/interface_response_router.sv
// Records granted master indices in issue order and routes in-order shared-slave
// responses back to their owners through a one-entry registered output stage.
module interface_response_router #(
   parameter int IN_COUNT   = 2,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input logic                         clk_i,
   input logic                         reset_i,
   interface_response_router_if.slave  bus
);
   localparam int SW = $clog2(IN_COUNT) + 1;
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [SW-1:0]         id_mem_q [DEPTH];
   logic [PW-1:0]         wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  out_full_q, out_full_d;
   logic [SW-1:0]         out_dst_q, out_dst_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic                  err_q, err_d;

   logic          full, push, pop, load, out_fire, rsp_acc;
   logic [SW-1:0] head;

   assign full    = (count_q == CW'(DEPTH));
   assign push    = bus.req_accept_i && !full;
   assign head    = id_mem_q[rd_q];
   assign rsp_acc = bus.rsp_valid_i && bus.rsp_ready_o;
   assign pop     = rsp_acc && (count_q != '0);
   assign load    = pop && (head < SW'(IN_COUNT));

   // Only the destination's ready bit matters; the others are ignored.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      out_fire = 1'b0;
      for (int k = 0; k < IN_COUNT; k++) begin
         if (out_dst_q == SW'(k) && bus.rsp_ready_i[k]) out_fire = out_full_q;
      end
   end

   always_comb begin
      wr_d       = wr_q;
      rd_d       = rd_q;
      count_d    = count_q;
      out_full_d = out_full_q;
      out_dst_d  = out_dst_q;
      out_data_d = out_data_q;
      err_d      = err_q;

      if (push) wr_d = wr_q + PW'(1);
      if (pop)  rd_d = rd_q + PW'(1);

      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      if (load) begin
         out_full_d = 1'b1;
         out_dst_d  = head;
         out_data_d = bus.rsp_data_i;
      end else if (out_fire) begin
         out_full_d = 1'b0;
      end

      // Overflowing push, undeliverable index and response with nothing pending.
      if ((bus.req_accept_i && full) || (pop && !load) || (rsp_acc && count_q == '0))
         err_d = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (reset_i) begin
         wr_q       <= '0;
         rd_q       <= '0;
         count_q    <= '0;
         out_full_q <= 1'b0;
         out_dst_q  <= '0;
         out_data_q <= '0;
         err_q      <= 1'b0;
      end else begin
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         count_q    <= count_d;
         out_full_q <= out_full_d;
         out_dst_q  <= out_dst_d;
         out_data_q <= out_data_d;
         err_q      <= err_d;
      end
   end

   // NOTE: the ID storage is not reset; the pointers and count alone define which entries are live.
   always_ff @(posedge clk_i) begin
      if (push) id_mem_q[wr_q] <= bus.req_sel_i;
   end

   always_comb begin
      bus.rsp_valid_o = '0;
      for (int k = 0; k < IN_COUNT; k++) begin
         bus.rsp_valid_o[k] = out_full_q && (out_dst_q == SW'(k));
      end
   end

   assign bus.req_stall_o   = full;
   assign bus.rsp_ready_o   = !out_full_q || out_fire;
   assign bus.rsp_data_o    = out_data_q;
   assign bus.outstanding_o = count_q;
   assign bus.err_o         = err_q;
endmodule
